reorder_buffer: RTL and testbench

- In-order retirement buffer behind rename: allocates one entry per renamed instruction, records out-of-order completion, and retires entries in program order, one per cycle.
- Drives the rename free-list return interface: push_free_reg/freed_reg return the retired instruction's previous physical mapping (old_rd) to the free list.
- Single commit width, no flush/recovery in this revision.

---
 rtl/reorder_buffer.sv | 125 ++++++++++++
 tb/tb_reorder_buffer.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_buffer.sv
// In-order retirement buffer: allocates at tail, marks out-of-order completions,
// retires done entries from head one per cycle and returns old physical mappings to the free list.
module reorder_buffer #(
  parameter int unsigned PREG_WIDTH = 6,
  parameter int unsigned AREG_WIDTH = 5,
  parameter int unsigned TAG_WIDTH  = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  alloc_valid,
  input  logic                  alloc_has_rd,
  input  logic [AREG_WIDTH-1:0] alloc_areg_rd,
  input  logic [PREG_WIDTH-1:0] alloc_prd,
  input  logic [PREG_WIDTH-1:0] alloc_old_prd,
  input  logic [11:0]           alloc_pc,
  output logic                  alloc_ready,
  output logic [TAG_WIDTH-1:0]  alloc_tag,
  input  logic                  cmpl_valid,
  input  logic [TAG_WIDTH-1:0]  cmpl_tag,
  output logic                  retire_valid,
  output logic [AREG_WIDTH-1:0] retire_areg,
  output logic [PREG_WIDTH-1:0] retire_prd,
  output logic [11:0]           retire_pc,
  output logic                  push_free_reg,
  output logic [PREG_WIDTH-1:0] freed_reg,
  output logic [TAG_WIDTH:0]    count
);

  localparam int unsigned DEPTH = 2 ** TAG_WIDTH;
  localparam logic [TAG_WIDTH:0] PTR_ONE    = {{TAG_WIDTH{1'b0}}, 1'b1};
  localparam logic [TAG_WIDTH:0] FULL_COUNT = {1'b1, {TAG_WIDTH{1'b0}}};

  logic [DEPTH-1:0]      valid_q, done_q, has_rd_q;
  logic [AREG_WIDTH-1:0] areg_q    [DEPTH];
  logic [PREG_WIDTH-1:0] prd_q     [DEPTH];
  logic [PREG_WIDTH-1:0] old_prd_q [DEPTH];
  logic [11:0]           pc_q      [DEPTH];

  logic [TAG_WIDTH:0]   head_q, head_d, tail_q, tail_d, count_q, count_d;
  logic [TAG_WIDTH-1:0] head_idx, tail_idx;
  logic                 alloc_fire, retire_fire;

  logic                  retire_valid_q, push_free_reg_q;
  logic [AREG_WIDTH-1:0] retire_areg_q;
  logic [PREG_WIDTH-1:0] retire_prd_q, freed_reg_q;
  logic [11:0]           retire_pc_q;

  assign head_idx    = head_q[TAG_WIDTH-1:0];
  assign tail_idx    = tail_q[TAG_WIDTH-1:0];
  // Readiness uses registered count only: a full buffer never reuses a slot freed this cycle.
  assign alloc_ready = (count_q != FULL_COUNT);
  assign alloc_tag   = tail_idx;
  assign count       = count_q;

  always_comb begin
    alloc_fire  = alloc_valid && alloc_ready;
    retire_fire = valid_q[head_idx] && done_q[head_idx];
    head_d      = retire_fire ? head_q + PTR_ONE : head_q;
    tail_d      = alloc_fire  ? tail_q + PTR_ONE : tail_q;
    count_d     = count_q;
    case ({alloc_fire, retire_fire})
      2'b10:   count_d = count_q + PTR_ONE;
      2'b01:   count_d = count_q - PTR_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q         <= '0;
      done_q          <= '0;
      head_q          <= '0;
      tail_q          <= '0;
      count_q         <= '0;
      retire_valid_q  <= 1'b0;
      push_free_reg_q <= 1'b0;
      retire_areg_q   <= '0;
      retire_prd_q    <= '0;
      retire_pc_q     <= '0;
      freed_reg_q     <= '0;
    end else begin
      if (cmpl_valid && valid_q[cmpl_tag]) begin
        done_q[cmpl_tag] <= 1'b1;
      end
      if (retire_fire) begin
        valid_q[head_idx] <= 1'b0;
      end
      // Allocation comes last so it overrides any completion aimed at the tail slot.
      if (alloc_fire) begin
        valid_q[tail_idx]  <= 1'b1;
        done_q[tail_idx]   <= 1'b0;
        has_rd_q[tail_idx] <= alloc_has_rd;
      end
      head_q          <= head_d;
      tail_q          <= tail_d;
      count_q         <= count_d;
      retire_valid_q  <= retire_fire;
      push_free_reg_q <= retire_fire && has_rd_q[head_idx] && (old_prd_q[head_idx] != '0);
      if (retire_fire) begin
        retire_areg_q <= areg_q[head_idx];
        retire_prd_q  <= prd_q[head_idx];
        retire_pc_q   <= pc_q[head_idx];
        freed_reg_q   <= old_prd_q[head_idx];
      end
    end
  end

  // Payload needs no reset: it is only read behind a set valid bit.
  always_ff @(posedge clk) begin
    if (alloc_fire) begin
      areg_q[tail_idx]    <= alloc_areg_rd;
      prd_q[tail_idx]     <= alloc_prd;
      old_prd_q[tail_idx] <= alloc_old_prd;
      pc_q[tail_idx]      <= alloc_pc;
    end
  end

  assign retire_valid  = retire_valid_q;
  assign push_free_reg = push_free_reg_q;
  assign retire_areg   = retire_areg_q;
  assign retire_prd    = retire_prd_q;
  assign retire_pc     = retire_pc_q;
  assign freed_reg     = freed_reg_q;

endmodule

// File: tb/tb_reorder_buffer.sv
// Directed self-checking bench for reorder_buffer: reset, single retire, out-of-order completion,
// full buffer, pointer wrap and non-freeing retires.
module tb_reorder_buffer;

  logic        clk = 1'b0;
  logic        rst;
  logic        alloc_valid, alloc_has_rd;
  logic [4:0]  alloc_areg_rd;
  logic [5:0]  alloc_prd, alloc_old_prd;
  logic [11:0] alloc_pc;
  logic        alloc_ready;
  logic [3:0]  alloc_tag;
  logic        cmpl_valid;
  logic [3:0]  cmpl_tag;
  logic        retire_valid;
  logic [4:0]  retire_areg;
  logic [5:0]  retire_prd;
  logic [11:0] retire_pc;
  logic        push_free_reg;
  logic [5:0]  freed_reg;
  logic [4:0]  count;

  int checks = 0;
  int errors = 0;

  logic       mon_en = 1'b0;
  logic [5:0] freed_q[$];
  int         max_count = 0;

  reorder_buffer #(.PREG_WIDTH(6), .AREG_WIDTH(5), .TAG_WIDTH(4)) dut (
    .clk           (clk),
    .rst           (rst),
    .alloc_valid   (alloc_valid),
    .alloc_has_rd  (alloc_has_rd),
    .alloc_areg_rd (alloc_areg_rd),
    .alloc_prd     (alloc_prd),
    .alloc_old_prd (alloc_old_prd),
    .alloc_pc      (alloc_pc),
    .alloc_ready   (alloc_ready),
    .alloc_tag     (alloc_tag),
    .cmpl_valid    (cmpl_valid),
    .cmpl_tag      (cmpl_tag),
    .retire_valid  (retire_valid),
    .retire_areg   (retire_areg),
    .retire_prd    (retire_prd),
    .retire_pc     (retire_pc),
    .push_free_reg (push_free_reg),
    .freed_reg     (freed_reg),
    .count         (count)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (mon_en) begin
      if (push_free_reg) freed_q.push_back(freed_reg);
      if (int'(count) > max_count) max_count = int'(count);
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  task automatic do_alloc(input logic has_rd, input logic [4:0] areg, input logic [5:0] prd,
                          input logic [5:0] old_prd, input logic [11:0] pc);
    alloc_valid   = 1'b1;
    alloc_has_rd  = has_rd;
    alloc_areg_rd = areg;
    alloc_prd     = prd;
    alloc_old_prd = old_prd;
    alloc_pc      = pc;
    tick();
    alloc_valid   = 1'b0;
  endtask

  task automatic do_cmpl(input logic [3:0] tag);
    cmpl_valid = 1'b1;
    cmpl_tag   = tag;
    tick();
    cmpl_valid = 1'b0;
  endtask

  task automatic test_reset;
    do_alloc(1'b1, 5'd1, 6'd10, 6'd11, 12'h100);
    do_alloc(1'b1, 5'd2, 6'd12, 6'd13, 12'h104);
    do_cmpl(4'd0);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    checks++;
    if (alloc_ready !== 1'b1 || alloc_tag !== 4'd0 || count !== 5'd0) begin
      errors++;
      $display("FAIL reset_state ready=%b tag=%0d count=%0d expected 1/0/0",
               alloc_ready, alloc_tag, count);
    end
    checks++;
    if (retire_valid !== 1'b0 || push_free_reg !== 1'b0 || freed_reg !== 6'd0) begin
      errors++;
      $display("FAIL reset_outputs rv=%b push=%b freed=%0d expected 0/0/0",
               retire_valid, push_free_reg, freed_reg);
    end
    tick();
    checks++;
    if (retire_valid !== 1'b0 || push_free_reg !== 1'b0 || count !== 5'd0) begin
      errors++;
      $display("FAIL reset_no_pulse rv=%b push=%b count=%0d expected 0/0/0",
               retire_valid, push_free_reg, count);
    end
  endtask

  task automatic test_single;
    do_reset();
    do_alloc(1'b1, 5'd3, 6'd33, 6'd3, 12'h004);
    do_cmpl(4'd0);
    checks++;
    if (retire_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_k1 rv=%b expected 0", retire_valid);
    end
    tick();
    checks++;
    if (retire_valid !== 1'b1 || retire_areg !== 5'd3 || retire_prd !== 6'd33 ||
        retire_pc !== 12'h004 || push_free_reg !== 1'b1 || freed_reg !== 6'd3) begin
      errors++;
      $display("FAIL single_k2 rv=%b areg=%0d prd=%0d pc=%h push=%b freed=%0d expected 1/3/33/004/1/3",
               retire_valid, retire_areg, retire_prd, retire_pc, push_free_reg, freed_reg);
    end
    tick();
    checks++;
    if (retire_valid !== 1'b0 || push_free_reg !== 1'b0 || count !== 5'd0) begin
      errors++;
      $display("FAIL single_k3 rv=%b push=%b count=%0d expected 0/0/0",
               retire_valid, push_free_reg, count);
    end
  endtask

  task automatic test_out_of_order;
    logic [5:0] exp_freed [3];
    exp_freed[0] = 6'd5;
    exp_freed[1] = 6'd6;
    exp_freed[2] = 6'd7;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (alloc_tag !== 4'(i)) begin
        errors++;
        $display("FAIL ooo_tag%0d tag=%0d expected %0d", i, alloc_tag, i);
      end
      do_alloc(1'b1, 5'(i + 1), 6'(40 + i), exp_freed[i], 12'(8 + 4 * i));
    end
    do_cmpl(4'd2);
    do_cmpl(4'd1);
    tick();
    checks++;
    if (retire_valid !== 1'b0 || count !== 5'd3) begin
      errors++;
      $display("FAIL ooo_hold rv=%b count=%0d expected 0/3", retire_valid, count);
    end
    do_cmpl(4'd0);
    checks++;
    if (retire_valid !== 1'b0) begin
      errors++;
      $display("FAIL ooo_no_bypass rv=%b expected 0", retire_valid);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (retire_valid !== 1'b1 || push_free_reg !== 1'b1 || freed_reg !== exp_freed[i]) begin
        errors++;
        $display("FAIL ooo_retire%0d rv=%b push=%b freed=%0d expected 1/1/%0d",
                 i, retire_valid, push_free_reg, freed_reg, exp_freed[i]);
      end
    end
    tick();
    checks++;
    if (retire_valid !== 1'b0 || count !== 5'd0) begin
      errors++;
      $display("FAIL ooo_drain rv=%b count=%0d expected 0/0", retire_valid, count);
    end
  endtask

  task automatic test_full;
    do_reset();
    for (int i = 0; i < 16; i++) do_alloc(1'b1, 5'd1, 6'(i + 1), 6'(i + 20), 12'(i));
    checks++;
    if (count !== 5'd16 || alloc_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_state count=%0d ready=%b expected 16/0", count, alloc_ready);
    end
    do_alloc(1'b1, 5'd9, 6'd63, 6'd62, 12'hFFF);
    checks++;
    if (count !== 5'd16 || alloc_tag !== 4'd0) begin
      errors++;
      $display("FAIL full_ignore count=%0d tag=%0d expected 16/0", count, alloc_tag);
    end
    do_cmpl(4'd0);
    checks++;
    if (count !== 5'd16 || alloc_ready !== 1'b0) begin
      errors++;
      $display("FAIL full_pre_retire count=%0d ready=%b expected 16/0", count, alloc_ready);
    end
    tick();
    checks++;
    if (retire_valid !== 1'b1 || freed_reg !== 6'd20 || count !== 5'd15 ||
        alloc_ready !== 1'b1 || alloc_tag !== 4'd0) begin
      errors++;
      $display("FAIL full_after_retire rv=%b freed=%0d count=%0d ready=%b tag=%0d expected 1/20/15/1/0",
               retire_valid, freed_reg, count, alloc_ready, alloc_tag);
    end
  endtask

  task automatic test_wrap;
    int tag_err;
    int ord_err;
    do_reset();
    freed_q.delete();
    max_count = 0;
    mon_en = 1'b1;
    tag_err = 0;
    for (int i = 0; i < 40; i++) begin
      if (alloc_tag !== 4'(i % 16)) begin
        tag_err++;
        $display("FAIL wrap_tag%0d tag=%0d expected %0d", i, alloc_tag, i % 16);
      end
      do_alloc(1'b1, 5'(i % 32), 6'(i + 1), 6'(i + 1), 12'(4 * i));
      do_cmpl(4'(i % 16));
    end
    tick();
    tick();
    tick();
    mon_en = 1'b0;
    checks++;
    if (tag_err != 0) begin
      errors++;
      $display("FAIL wrap_tags bad=%0d expected 0", tag_err);
    end
    checks++;
    if (freed_q.size() != 40) begin
      errors++;
      $display("FAIL wrap_free_count got=%0d expected 40", freed_q.size());
    end
    ord_err = 0;
    for (int i = 0; i < freed_q.size() && i < 40; i++) begin
      if (freed_q[i] !== 6'(i + 1)) begin
        ord_err++;
        $display("FAIL wrap_order%0d freed=%0d expected %0d", i, freed_q[i], i + 1);
      end
    end
    checks++;
    if (ord_err != 0) begin
      errors++;
      $display("FAIL wrap_order bad=%0d expected 0", ord_err);
    end
    checks++;
    if (max_count > 16 || count !== 5'd0) begin
      errors++;
      $display("FAIL wrap_count max=%0d final=%0d expected <=16/0", max_count, count);
    end
  endtask

  task automatic test_no_free;
    do_reset();
    do_alloc(1'b0, 5'd0, 6'd0, 6'd9, 12'h010);
    do_alloc(1'b1, 5'd4, 6'd20, 6'd0, 12'h014);
    do_cmpl(4'd0);
    do_cmpl(4'd1);
    checks++;
    if (retire_valid !== 1'b1 || push_free_reg !== 1'b0 || retire_pc !== 12'h010) begin
      errors++;
      $display("FAIL nofree_store rv=%b push=%b pc=%h expected 1/0/010",
               retire_valid, push_free_reg, retire_pc);
    end
    tick();
    checks++;
    if (retire_valid !== 1'b1 || push_free_reg !== 1'b0 || retire_pc !== 12'h014 ||
        retire_areg !== 5'd4 || retire_prd !== 6'd20) begin
      errors++;
      $display("FAIL nofree_preg0 rv=%b push=%b pc=%h areg=%0d prd=%0d expected 1/0/014/4/20",
               retire_valid, push_free_reg, retire_pc, retire_areg, retire_prd);
    end
  endtask

  task automatic test_ignored_cmpl;
    do_reset();
    do_cmpl(4'd0);
    do_alloc(1'b1, 5'd7, 6'd17, 6'd18, 12'h020);
    tick();
    tick();
    tick();
    checks++;
    if (retire_valid !== 1'b0 || count !== 5'd1) begin
      errors++;
      $display("FAIL ignored_cmpl rv=%b count=%0d expected 0/1", retire_valid, count);
    end
  endtask

  initial begin
    rst           = 1'b1;
    alloc_valid   = 1'b0;
    alloc_has_rd  = 1'b0;
    alloc_areg_rd = '0;
    alloc_prd     = '0;
    alloc_old_prd = '0;
    alloc_pc      = '0;
    cmpl_valid    = 1'b0;
    cmpl_tag      = '0;
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    test_single();
    test_out_of_order();
    test_full();
    test_wrap();
    test_no_free();
    test_ignored_cmpl();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
